// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first.
// The line is synchronised and sampled once at the middle of each bit.
// A correctly framed byte is presented on po_data with a one-cycle po_flag.
// A frame whose stop bit is low gives a one-cycle frame_err instead.
// The baud timing is derived from the same parameters as uart_tx.
module uart_rx #(
  parameter int UART_BAUD_RATE = 9600,
  parameter int CLK_FREQ       = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rstn,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);

  // Derived timing. These are not overridable: a mismatch with the
  // transmitter must come only from UART_BAUD_RATE / CLK_FREQ.
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BAUD_RATE;
  localparam int BAUD_CNT_MID = BAUD_CNT_MAX / 2;
  // The counter only reaches BAUD_CNT_MAX-1, so $clog2(BAUD_CNT_MAX) bits are enough.
  localparam int CNT_W = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MID);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;

  // Input conditioning.
  logic             rx_meta;   // first synchroniser stage
  logic             rx_s;      // second stage: the sampled line value
  logic             rx_d;      // third stage, used only for edge detect
  logic [1:0]       sync_fill; // shows when rx_s holds a real pin sample
  logic             armed;     // line has been seen high since reset
  logic             start_edge;

  // Bit timing and data capture.
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  // Per-cycle decisions from the output process.
  logic             sample;
  logic             take_bit;
  logic             load_data;
  logic             set_err;

  // Two-flop synchroniser plus an edge-detect flop; all reset to the idle level.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, so this really is a three-flop chain. Blocking
      // assignments would let rx pass straight through in one cycle.
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Arm start detection only after a real high level has been sampled.
  // The flops reset to 1. If the line is low at release, that would look
  // like a falling edge, so detection waits for a genuine high first.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign start_edge = armed && rx_d && !rx_s;

  // Baud counter: held at 0 in IDLE and on the way back to IDLE, otherwise
  // it wraps every bit period. It keeps running across START/DATA/STOP.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      baud_cnt <= '0;
    end else if (state == IDLE || state_next == IDLE) begin
      baud_cnt <= '0;
    end else if (baud_cnt == CNT_LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_ONE;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: assigning a default first means every path drives state_next,
    // so no latch is inferred when a branch has nothing to change.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_edge) begin
          state_next = START;
        end
      end
      START: begin
        // If the line is high again at mid start bit, it was a glitch.
        if (sample) begin
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample && bit_idx == 3'd7) begin
          state_next = STOP;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (sample) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM output decisions, made at the mid-bit sample point.
  always_comb begin
    sample    = (baud_cnt == CNT_MID);
    take_bit  = 1'b0;
    load_data = 1'b0;
    set_err   = 1'b0;
    unique case (state)
      DATA:    take_bit  = sample;
      STOP: begin
        load_data = sample && rx_s;
        set_err   = sample && !rx_s;
      end
      default: ;
    endcase
  end

  // Bit index and shift register: data bits are stored LSB first.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      bit_idx   <= 3'd0;
      // NOTE: the shift register is reset only to keep it deterministic.
      // Its contents are never visible until all eight bits are overwritten.
      shift_reg <= 8'h00;
    end else begin
      if (state == START && sample) begin
        bit_idx <= 3'd0;
      end else if (take_bit) begin
        bit_idx            <= bit_idx + 3'd1;
        shift_reg[bit_idx] <= rx_s;
      end
    end
  end

  // Registered outputs. The two pulses are mutually exclusive by
  // construction, and po_data moves only when po_flag rises.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      po_data   <= 8'h00;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      po_flag   <= load_data;
      frame_err <= set_err;
      if (load_data) begin
        po_data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 100 clocks per bit
// (CLK_FREQ=1_000_000, UART_BAUD_RATE=10_000, BAUD_CNT_MID=50).
module tb_uart_rx;

  localparam int PER = 100;
  localparam int MID = 50;
  localparam int LAT = 9 * PER + MID + 3;  // 953 clocks from rx fall to pulse

  logic       sys_clk;
  logic       sys_rstn;
  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;

  int cyc          = 0;
  int fall_cyc     = 0;
  int last_flag    = 0;
  int flag_cnt     = 0;
  int err_cnt      = 0;
  int both_cnt     = 0;
  int stray_data   = 0;
  logic [7:0] prev_data = 8'h00;

  int f0;
  int e0;

  uart_rx #(
    .UART_BAUD_RATE(10_000),
    .CLK_FREQ      (1_000_000)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .rx       (rx),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .frame_err(frame_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (!sys_rstn) begin
      prev_data <= po_data;
    end else begin
      if (po_flag) begin
        flag_cnt  <= flag_cnt + 1;
        last_flag <= cyc;
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if (po_flag && frame_err) both_cnt <= both_cnt + 1;
      if (po_data != prev_data && !po_flag) stray_data <= stray_data + 1;
      prev_data <= po_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait n clocks. Every task starts and ends 1 time unit after a rising edge.
  task automatic wait_clks(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
    rx       = 1'b0;
    fall_cyc = cyc;
    wait_clks(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(per);
    end
    rx = stop;
    wait_clks(per);
    rx = 1'b1;
  endtask

  initial begin
    int lat;
    rx       = 1'b0;
    sys_rstn = 1'b0;
    #23;
    check("rst_data", {24'd0, po_data}, 32'h00);
    check("rst_flag", {31'd0, po_flag}, 32'd0);
    check("rst_err",  {31'd0, frame_err}, 32'd0);

    // The line is low when reset releases. No frame may start until a real fall.
    @(posedge sys_clk); #1;
    sys_rstn = 1'b1;
    wait_clks(3 * PER);
    rx = 1'b1;
    wait_clks(12 * PER);
    check("lowrel_flag", flag_cnt, 0);
    check("lowrel_err",  err_cnt, 0);

    // Nominal frame 0x55, with latency measurement.
    send_frame(8'h55, PER, 1'b1);
    wait_clks(5);
    lat = last_flag - fall_cyc;
    check("f55_data", {24'd0, po_data}, 32'h55);
    check("f55_flag", flag_cnt, 1);
    check("f55_err",  err_cnt, 0);
    check("f55_lat", ((lat >= LAT - 2) && (lat <= LAT + 2)) ? LAT : lat, LAT);

    // Back-to-back bytes 0x00..0x07, as a transmitter would send them.
    f0 = flag_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 8; i++) begin
      send_frame(8'(i), PER, 1'b1);
      check($sformatf("b2b_data%0d", i), {24'd0, po_data}, i);
    end
    wait_clks(5);
    check("b2b_flags", flag_cnt - f0, 8);
    check("b2b_err",   err_cnt - e0, 0);

    // A short low glitch is rejected at the start-bit sample.
    f0 = flag_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    wait_clks(30);
    rx = 1'b1;
    wait_clks(15 * PER);
    check("glitch_flag", flag_cnt - f0, 0);
    check("glitch_err",  err_cnt - e0, 0);
    check("glitch_data", {24'd0, po_data}, 32'h07);

    // A stop bit sampled low gives frame_err and keeps po_data.
    f0 = flag_cnt;
    e0 = err_cnt;
    send_frame(8'hA3, PER, 1'b0);
    wait_clks(PER);
    check("ferr_err",  err_cnt - e0, 1);
    check("ferr_flag", flag_cnt - f0, 0);
    check("ferr_data", {24'd0, po_data}, 32'h07);
    send_frame(8'h3C, PER, 1'b1);
    wait_clks(5);
    check("after_ferr_data", {24'd0, po_data}, 32'h3C);
    check("after_ferr_flag", flag_cnt - f0, 1);

    // Reset in the middle of bit 4 of frame 0xFF.
    rx = 1'b0;
    wait_clks(PER);
    rx = 1'b1;
    wait_clks(4 * PER + PER / 2);
    sys_rstn = 1'b0;
    #1;
    check("midrst_data", {24'd0, po_data}, 32'h00);
    check("midrst_flag", {31'd0, po_flag}, 32'd0);
    wait_clks(5);
    sys_rstn = 1'b1;
    f0 = flag_cnt;
    e0 = err_cnt;
    wait_clks(2 * PER);
    check("midrst_quiet", flag_cnt - f0 + err_cnt - e0, 0);
    send_frame(8'h81, PER, 1'b1);
    wait_clks(5);
    check("post_rst_data", {24'd0, po_data}, 32'h81);
    check("post_rst_flag", flag_cnt - f0, 1);

    // Transmitter running 3% slow and 3% fast.
    f0 = flag_cnt;
    send_frame(8'hC6, 103, 1'b1);
    wait_clks(5);
    check("slow_data", {24'd0, po_data}, 32'hC6);
    send_frame(8'h39, 97, 1'b1);
    wait_clks(5);
    check("fast_data", {24'd0, po_data}, 32'h39);
    check("tol_flags", flag_cnt - f0, 2);

    // Break: the line is held low for many bit times, which gives exactly one frame_err.
    f0 = flag_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    wait_clks(25 * PER);
    check("break_err",  err_cnt - e0, 1);
    check("break_flag", flag_cnt - f0, 0);
    rx = 1'b1;
    wait_clks(3 * PER);
    send_frame(8'h5A, PER, 1'b1);
    wait_clks(5);
    check("after_break_data", {24'd0, po_data}, 32'h5A);
    check("after_break_err",  err_cnt - e0, 1);

    // Properties over the whole run.
    check("never_both",      both_cnt, 0);
    check("data_only_on_flag", stray_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
